clock_scan_display: RTL and testbench

- Downstream display stage for the 24-hour BCD clock counter.
- Takes the six BCD time digits (HH:MM:SS) and time-multiplexes them onto one shared 7-segment bus with a one-hot digit select.
- Takes a coherent snapshot of the time once per scan frame, so the display never tears.
- Supports per-digit blinking for time-setting and blanks a leading zero on the hour tens digit.

---
 rtl/clock_scan_display_if.sv | 30 +++
 rtl/clock_scan_display.sv | 182 ++++++++++++++++++
 tb/tb_clock_scan_display.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_scan_display_if.sv
// Time/blink inputs and scanned 7-segment outputs.
// master: time source side; slave: display stage.
interface clock_scan_display_if;
  logic [3:0] sec_l;
  logic [2:0] sec_h;
  logic [3:0] min_l;
  logic [2:0] min_h;
  logic [3:0] hour_l;
  logic [1:0] hour_h;
  logic [5:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_sel;

  modport master (
    output sec_l, sec_h,
    output min_l, min_h,
    output hour_l, hour_h,
    output blink_mask,
    input  seg, dp, dig_sel
  );

  modport slave (
    input  sec_l, sec_h,
    input  min_l, min_h,
    input  hour_l, hour_h,
    input  blink_mask,
    output seg, dp, dig_sel
  );
endinterface

// File: rtl/clock_scan_display.sv
// Scans six BCD time digits onto one 7-seg bus.
// Ports: clk, clr (async low), bus (slave).
module clock_scan_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50,
  parameter bit LZ_BLANK  = 1'b1
) (
  input logic clk,
  input logic clr,
  clock_scan_display_if.slave bus
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX =
    FW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    D_SL = 3'd0,
    D_SH = 3'd1,
    D_ML = 3'd2,
    D_MH = 3'd3,
    D_HL = 3'd4,
    D_HH = 3'd5
  } idx_t;

  function automatic logic [6:0] seg_of(
    input logic [3:0] v
  );
    logic [6:0] s;
    s = 7'b0000000;
    unique case (v)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111100;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1100111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]   pre_q;
  logic            tick;
  idx_t            idx_q;
  idx_t            idx_nx;
  logic            wrap;
  logic [5:0][3:0] live;
  logic [5:0][3:0] snap_q;
  logic [FW-1:0]   frm_q;
  logic            frm_end;
  logic            phase_q;
  logic            phase_nx;
  logic [3:0]      val;
  logic            blank;
  logic [6:0]      seg_nx;
  logic            dp_nx;
  logic [5:0]      sel_nx;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic [5:0]      sel_q;

  assign tick = (pre_q == PRE_MAX);
  assign wrap = tick && (idx_q == D_HH);

  assign live[0] = bus.sec_l;
  assign live[1] = {1'b0, bus.sec_h};
  assign live[2] = bus.min_l;
  assign live[3] = {1'b0, bus.min_h};
  assign live[4] = bus.hour_l;
  assign live[5] = {2'b00, bus.hour_h};

  assign frm_end  = (frm_q == FRM_MAX);
  // A toggle on the wrap edge already
  // governs the digit loaded on that edge.
  assign phase_nx = phase_q ^ (wrap && frm_end);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx_q <= D_HH;
    end else if (tick) begin
      idx_q <= idx_nx;
    end
  end

  always_comb begin
    idx_nx = D_SL;
    unique case (idx_q)
      D_SL: idx_nx = D_SH;
      D_SH: idx_nx = D_ML;
      D_ML: idx_nx = D_MH;
      D_MH: idx_nx = D_HL;
      D_HL: idx_nx = D_HH;
      D_HH: idx_nx = D_SL;
      default: idx_nx = D_SL;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snap_q <= '0;
    end else if (wrap) begin
      snap_q <= live;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      phase_q <= phase_nx;
      if (frm_end) begin
        frm_q <= '0;
      end else begin
        frm_q <= frm_q + 1'b1;
      end
    end
  end

  // Digit 0 on the wrap edge comes from the
  // live inputs the snapshot is loading now.
  always_comb begin
    val    = snap_q[idx_nx];
    blank  = 1'b0;
    seg_nx = 7'b0000000;
    dp_nx  = 1'b0;
    sel_nx = 6'b111111;
    if (wrap) begin
      val = live[idx_nx];
    end
    if (phase_nx && bus.blink_mask[idx_nx]) begin
      blank = 1'b1;
    end
    if (LZ_BLANK && (idx_nx == D_HH) &&
        (val == 4'd0)) begin
      blank = 1'b1;
    end
    if (!blank) begin
      seg_nx = seg_of(val);
      dp_nx  = (idx_nx == D_ML) ||
               (idx_nx == D_HL);
    end
    sel_nx = ~(6'b000001 << idx_nx);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      seg_q <= 7'b0000000;
      dp_q  <= 1'b0;
      sel_q <= 6'b111111;
    end else if (tick) begin
      seg_q <= seg_nx;
      dp_q  <= dp_nx;
      sel_q <= sel_nx;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.dig_sel = sel_q;

endmodule

// File: tb/tb_clock_scan_display.sv
// Directed bench for clock_scan_display.
// Two instances: leading-zero blank on/off.
module tb_clock_scan_display;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111100;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1100111;
  localparam logic [6:0] SB = 7'b0000000;

  typedef struct {
    logic [23:0] t;
    logic [5:0]  mask;
    int          idx;
    logic [6:0]  seg;
    logic        dp;
    logic [6:0]  seg1;
  } row_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [23:0] tin;
  logic [5:0]  mask;
  int n_tests = 0;
  int n_fail  = 0;
  row_t rows[$];

  clock_scan_display_if bus0 ();
  clock_scan_display_if bus1 ();

  assign bus0.sec_l      = tin[3:0];
  assign bus0.sec_h      = tin[6:4];
  assign bus0.min_l      = tin[11:8];
  assign bus0.min_h      = tin[14:12];
  assign bus0.hour_l     = tin[19:16];
  assign bus0.hour_h     = tin[21:20];
  assign bus0.blink_mask = mask;
  assign bus1.sec_l      = tin[3:0];
  assign bus1.sec_h      = tin[6:4];
  assign bus1.min_l      = tin[11:8];
  assign bus1.min_h      = tin[14:12];
  assign bus1.hour_l     = tin[19:16];
  assign bus1.hour_h     = tin[21:20];
  assign bus1.blink_mask = mask;

  clock_scan_display #(
    .SCAN_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1'b1)
  ) dut0 (
    .clk(clk), .clr(clr), .bus(bus0.slave)
  );

  clock_scan_display #(
    .SCAN_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1'b0)
  ) dut1 (
    .clk(clk), .clr(clr), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic add(
    input logic [23:0] t,
    input logic [5:0]  m,
    input int          idx,
    input logic [6:0]  s,
    input logic        d,
    input logic [6:0]  s1
  );
    row_t r;
    r.t = t; r.mask = m; r.idx = idx;
    r.seg = s; r.dp = d; r.seg1 = s1;
    rows.push_back(r);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " sel0"}, {2'b0, bus0.dig_sel},
        8'h3f);
    chk({tag, " seg0"}, {1'b0, bus0.seg}, 8'h00);
    chk({tag, " dp0"}, {7'b0, bus0.dp}, 8'h00);
    chk({tag, " sel1"}, {2'b0, bus1.dig_sel},
        8'h3f);
  endtask

  task automatic chk_slot(
    input string tag, input int idx,
    input logic [6:0] s, input logic d
  );
    logic [5:0] sel;
    sel = ~(6'b000001 << idx);
    chk({tag, " sel"}, {2'b0, bus0.dig_sel},
        {2'b0, sel});
    chk({tag, " seg"}, {1'b0, bus0.seg},
        {1'b0, s});
    chk({tag, " dp"}, {7'b0, bus0.dp}, {7'b0, d});
  endtask

  initial begin
    // frame 1: 12:34:56
    add(24'h123456, 6'h00, 0, S6, 0, S6);
    add(24'h123456, 6'h00, 1, S5, 0, S5);
    add(24'h123456, 6'h00, 2, S4, 1, S4);
    add(24'h123456, 6'h00, 3, S3, 0, S3);
    add(24'h123456, 6'h00, 4, S2, 1, S2);
    add(24'h123456, 6'h00, 5, S1, 0, S1);
    // frame 2: inputs change mid-frame
    add(24'h123456, 6'h00, 0, S6, 0, S6);
    add(24'h123456, 6'h00, 1, S5, 0, S5);
    add(24'h134557, 6'h00, 2, S4, 1, S4);
    add(24'h134557, 6'h00, 3, S3, 0, S3);
    add(24'h134557, 6'h00, 4, S2, 1, S2);
    add(24'h134557, 6'h00, 5, S1, 0, S1);
    // frame 3: blink phase on, hours masked
    add(24'h134557, 6'h30, 0, S7, 0, S7);
    add(24'h134557, 6'h30, 1, S5, 0, S5);
    add(24'h134557, 6'h30, 2, S5, 1, S5);
    add(24'h134557, 6'h30, 3, S4, 0, S4);
    add(24'h134557, 6'h30, 4, SB, 0, SB);
    add(24'h134557, 6'h30, 5, SB, 0, SB);
    // frame 4: blink phase off
    add(24'h134557, 6'h30, 0, S7, 0, S7);
    add(24'h134557, 6'h30, 1, S5, 0, S5);
    add(24'h134557, 6'h30, 2, S5, 1, S5);
    add(24'h134557, 6'h30, 3, S4, 0, S4);
    add(24'h134557, 6'h30, 4, S3, 1, S3);
    add(24'h134557, 6'h30, 5, S1, 0, S1);
    // frame 5: leading zero 09:05:00
    add(24'h090500, 6'h00, 0, S0, 0, S0);
    add(24'h090500, 6'h00, 1, S0, 0, S0);
    add(24'h090500, 6'h00, 2, S5, 1, S5);
    add(24'h090500, 6'h00, 3, S0, 0, S0);
    add(24'h090500, 6'h00, 4, S9, 1, S9);
    add(24'h090500, 6'h00, 5, SB, 0, S0);
    // frame 6: invalid sec_l, blink on
    add(24'h09050C, 6'h30, 0, SB, 0, SB);
    add(24'h09050C, 6'h30, 1, S0, 0, S0);
    add(24'h09050C, 6'h30, 2, S5, 1, S5);
    add(24'h09050C, 6'h30, 3, S0, 0, S0);
    add(24'h09050C, 6'h30, 4, SB, 0, SB);
    add(24'h09050C, 6'h30, 5, SB, 0, SB);

    tin  = 24'h123456;
    mask = 6'h00;
    repeat (2) @(negedge clk);
    chk_dark("in_reset");
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_dark($sformatf("dark%0d", k));
    end

    for (int i = 0; i < rows.size(); i++) begin
      tin  = rows[i].t;
      mask = rows[i].mask;
      repeat ((i == 0) ? 1 : 4) @(posedge clk);
      #1;
      chk_slot($sformatf("r%0d", i), rows[i].idx,
               rows[i].seg, rows[i].dp);
      chk($sformatf("r%0d seg_nolz", i),
          {1'b0, bus1.seg}, {1'b0, rows[i].seg1});
    end

    // run to digit 3 of the next frame
    repeat (16) @(posedge clk);
    #1;
    chk_slot("pre_rst", 3, S0, 1'b0);
    #2;
    clr  = 1'b0;
    tin  = 24'h214308;
    mask = 6'h00;
    #1;
    chk_dark("async_rst");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_dark($sformatf("rdark%0d", k));
    end
    @(posedge clk); #1;
    chk_slot("rst_d0", 0, S8, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk_slot("rst_d1", 1, S0, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk_slot("rst_d2", 2, S3, 1'b1);
    repeat (12) @(posedge clk); #1;
    chk_slot("rst_d5", 5, S2, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
